// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: opcode encodings and FSM states.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shifts are the only iterative operations.
    function automatic logic is_shift(op_t o);
        return (o == OP_SHL) || (o == OP_SHR);
    endfunction

endpackage

// File: rtl/prefix_adder_n.sv
// Parametrised Kogge-Stone prefix adder with carry-in and carry-out.
module prefix_adder_n #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int L = $clog2(W);

    logic [W:0] carry;

    genvar gi, gj;
    generate
        // Level 0 holds bit generate/propagate; level s spans 2^s bits.
        for (gi = 0; gi <= L; gi++) begin : stg
            logic [W-1:0] g;
            logic [W-1:0] p;
            if (gi == 0) begin : leaf
                assign g = a & b;
                assign p = a ^ b;
            end else begin : merge
                for (gj = 0; gj < W; gj++) begin : bitn
                    if (gj >= (1 << (gi - 1))) begin : span
                        assign g[gj] = stg[gi-1].g[gj]
                                     | (stg[gi-1].p[gj] & stg[gi-1].g[gj - (1 << (gi - 1))]);
                        assign p[gj] = stg[gi-1].p[gj] & stg[gi-1].p[gj - (1 << (gi - 1))];
                    end else begin : pass
                        assign g[gj] = stg[gi-1].g[gj];
                        assign p[gj] = stg[gi-1].p[gj];
                    end
                end
            end
        end
    endgenerate

    // Final level groups cover bits 0..i, so cin folds in with one AND-OR.
    assign carry = {stg[L].g | (stg[L].p & {W{cin}}), cin};
    assign sum   = stg[0].p ^ carry[W-1:0];
    assign cout  = carry[W];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU with register file, iterative shifter and valid/ready handshakes.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W    = 8,
    parameter int NREG = 4,
    localparam int RW  = $clog2(NREG)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [RW-1:0] rd,
    input  logic [RW-1:0] ra,
    input  logic [RW-1:0] rb,
    input  logic          imm_en,
    input  logic [W-1:0]  imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_carry,
    output logic          out_zero
);

    state_t        state, state_next;
    op_t           op_reg;
    logic [RW-1:0] rd_reg;
    logic [W-1:0]  a_reg, b_reg, cnt_reg;
    logic [W-1:0]  rf [NREG];

    logic          accept, done, wr_en;
    logic [W-1:0]  operand_b;
    logic [W-1:0]  res_data, sh_data;
    logic          res_carry, sh_bit;
    logic [W-1:0]  add_b, add_sum;
    logic          add_cin, add_cout;
    logic          cnt_zero, cnt_big;

    assign accept    = in_valid && in_ready;
    assign operand_b = imm_en ? imm : rf[rb];
    assign wr_en     = (state == EXEC) && done && (rd_reg != '0);

    // SUB is A + ~B + 1 through the same adder.
    assign add_b   = (op_reg == OP_SUB) ? ~b_reg : b_reg;
    assign add_cin = (op_reg == OP_SUB);

    prefix_adder_n #(.W(W)) u_adder (
        .a    (a_reg),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Shift counts of W or more flush everything out in a single cycle.
    assign cnt_zero = (cnt_reg == '0);
    assign cnt_big  = ({1'b0, cnt_reg} >= (W+1)'(W));

    // One-bit shift step and the bit it pushes out.
    always_comb begin
        if (op_reg == OP_SHL) begin
            sh_data = {a_reg[W-2:0], 1'b0};
            sh_bit  = a_reg[W-1];
        end else begin
            sh_data = {1'b0, a_reg[W-1:1]};
            sh_bit  = a_reg[0];
        end
    end

    // Result and completion for the current EXEC cycle.
    always_comb begin
        res_data  = '0;
        res_carry = 1'b0;
        done      = 1'b1;
        case (op_reg)
            OP_ADD, OP_SUB: begin
                res_data  = add_sum;
                res_carry = add_cout;
            end
            OP_AND: res_data = a_reg & b_reg;
            OP_OR:  res_data = a_reg | b_reg;
            OP_XOR: res_data = a_reg ^ b_reg;
            OP_NOT: res_data = ~a_reg;
            OP_SHL, OP_SHR: begin
                if (cnt_zero) begin
                    res_data = a_reg;
                end else if (!cnt_big) begin
                    res_data  = sh_data;
                    res_carry = sh_bit;
                    done      = (cnt_reg == W'(1));
                end
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; instructions are only looked at in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = EXEC;
            EXEC:    if (done) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Operand latch, shift iteration and result/flag capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_reg    <= OP_ADD;
            rd_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            cnt_reg   <= '0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
        end else if (accept) begin
            op_reg  <= op_t'(op);
            rd_reg  <= rd;
            a_reg   <= rf[ra];
            b_reg   <= operand_b;
            cnt_reg <= operand_b;
        end else if (state == EXEC) begin
            if (done) begin
                out_data  <= res_data;
                out_carry <= res_carry;
                out_zero  <= (res_data == '0);
            end else if (is_shift(op_reg)) begin
                a_reg   <= sh_data;
                cnt_reg <= cnt_reg - W'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : regs
            if (gi == 0) begin : zero
                assign rf[gi] = '0;
            end else begin : word
                logic [W-1:0] q;
                // Write-back on completion; reset clears the whole file.
                always_ff @(posedge clock or negedge reset) begin
                    if (!reset)                         q <= '0;
                    else if (wr_en && rd_reg == RW'(gi)) q <= res_data;
                end
                assign rf[gi] = q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer (W=8, NREG=4).
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op_in = 3'd0;
    logic [1:0] rd = 2'd0, ra = 2'd0, rb = 2'd0;
    logic       imm_en = 1'b0;
    logic [7:0] imm = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_carry, out_zero;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.W(8), .NREG(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_in),
        .rd        (rd),
        .ra        (ra),
        .rb        (rb),
        .imm_en    (imm_en),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction and wait for its result (does not release it).
    task automatic run(input string tag, input logic [2:0] o, input logic [1:0] d,
                       input logic [1:0] a, input logic [1:0] b, input logic ie,
                       input logic [7:0] im, input logic [7:0] ed, input logic ec,
                       input logic ez, input int el);
        int lat;
        @(negedge clock);
        in_valid = 1'b1; op_in = o; rd = d; ra = a; rb = b; imm_en = ie; imm = im;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk({tag, ".busy"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, ".lat"}, lat, el);
        chk({tag, ".data"}, out_data, ed);
        chk({tag, ".carry"}, out_carry, ec);
        chk({tag, ".zero"}, out_zero, ez);
    endtask

    // Full instruction with out_ready held high: result released next edge.
    task automatic step(input string tag, input logic [2:0] o, input logic [1:0] d,
                        input logic [1:0] a, input logic [1:0] b, input logic ie,
                        input logic [7:0] im, input logic [7:0] ed, input logic ec,
                        input logic ez, input int el);
        run(tag, o, d, a, b, ie, im, ed, ec, ez, el);
        @(posedge clock); #1;
        chk({tag, ".idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Linear directed sequence.
    initial begin
        #3;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out", {out_data, out_carry, out_zero}, 10'd0);
        @(negedge clock); reset = 1'b1;

        // Load and add
        step("add_load", OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0, 1);
        step("add_wrap", OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'hA6, 8'h00, 1'b1, 1'b1, 1);
        step("read_r2",  OP_ADD, 2'd3, 2'd2, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1);

        // Subtract
        step("sub_borrow", OP_SUB, 2'd3, 2'd0, 2'd0, 1'b1, 8'h01, 8'hFF, 1'b0, 1'b0, 1);
        step("sub_equal",  OP_SUB, 2'd2, 2'd1, 2'd0, 1'b1, 8'h5A, 8'h00, 1'b1, 1'b1, 1);
        step("add_regs",   OP_ADD, 2'd2, 2'd1, 2'd3, 1'b0, 8'h00, 8'h59, 1'b1, 1'b0, 1);

        // Shifts
        step("shl3",  OP_SHL, 2'd1, 2'd1, 2'd0, 1'b1, 8'd3, 8'hD0, 1'b0, 1'b0, 3);
        step("shr4",  OP_SHR, 2'd3, 2'd3, 2'd0, 1'b1, 8'd4, 8'h0F, 1'b1, 1'b0, 4);
        step("shl7",  OP_SHL, 2'd3, 2'd3, 2'd0, 1'b1, 8'd7, 8'h80, 1'b1, 1'b0, 7);
        step("shl8",  OP_SHL, 2'd0, 2'd3, 2'd0, 1'b1, 8'd8, 8'h00, 1'b0, 1'b1, 1);
        step("shr9",  OP_SHR, 2'd1, 2'd1, 2'd0, 1'b1, 8'd9, 8'h00, 1'b0, 1'b1, 1);
        step("shr0",  OP_SHR, 2'd2, 2'd2, 2'd0, 1'b1, 8'd0, 8'h59, 1'b0, 1'b0, 1);

        // Logic ops with r1 = 0xF0
        step("load_f0", OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'hF0, 8'hF0, 1'b0, 1'b0, 1);
        step("and", OP_AND, 2'd2, 2'd1, 2'd0, 1'b1, 8'h3C, 8'h30, 1'b0, 1'b0, 1);
        step("or",  OP_OR,  2'd2, 2'd1, 2'd0, 1'b1, 8'h3C, 8'hFC, 1'b0, 1'b0, 1);
        step("xor", OP_XOR, 2'd2, 2'd1, 2'd0, 1'b1, 8'h3C, 8'hCC, 1'b0, 1'b0, 1);
        step("not", OP_NOT, 2'd2, 2'd1, 2'd0, 1'b1, 8'h3C, 8'h0F, 1'b0, 1'b0, 1);

        // Backpressure: result held, stray instructions ignored
        out_ready = 1'b0;
        run("bp", OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 8'hF1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            in_valid = 1'b1; op_in = OP_ADD; rd = 2'd2; ra = 2'd0; imm_en = 1'b1; imm = 8'h33;
            @(posedge clock); #1;
            in_valid = 1'b0;
            chk("bp.hold", {out_valid, in_ready, out_data}, {2'b10, 8'hF1});
        end
        @(negedge clock); out_ready = 1'b1;
        @(posedge clock); #1;
        chk("bp.release", {in_ready, out_valid, out_data}, {2'b10, 8'hF1});
        step("bp.r2", OP_ADD, 2'd3, 2'd2, 2'd0, 1'b1, 8'h00, 8'hF1, 1'b0, 1'b0, 1);

        // Reset in the middle of SHL by 6
        @(negedge clock);
        in_valid = 1'b1; op_in = OP_SHL; rd = 2'd1; ra = 2'd3; imm_en = 1'b1; imm = 8'd6;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        chk("mid.busy", {in_ready, out_valid}, 2'b00);
        @(negedge clock); reset = 1'b0;
        #1;
        chk("mid.handshake", {in_ready, out_valid}, 2'b10);
        chk("mid.out", {out_data, out_carry, out_zero}, 10'd0);
        repeat (3) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        step("rst.r1", OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1);
        step("rst.r2", OP_ADD, 2'd2, 2'd2, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1);
        step("rst.r3", OP_ADD, 2'd3, 2'd3, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1);

        // r0 discards writes
        step("r0.write", OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h77, 8'h77, 1'b0, 1'b0, 1);
        step("r0.read",  OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
